// File: rtl/uart_pkg.sv
// Shared UART definitions: line FSM state encoding and default bit period.
// Used by both the TX and RX sides of the Bluetooth link.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 260;

endpackage

// File: rtl/uart_frame_tx_if.sv
// Frame handshake between a frame source and the UART transmitter.
// A frame transfers on a clock edge where frame_valid && frame_ready are both high;
// the source keeps frame_data stable while frame_valid is high and frame_ready is low.
interface uart_frame_tx_if #(
  parameter int FRAME_W = 24
);

  logic [FRAME_W-1:0] frame_data;
  logic               frame_valid;
  logic               frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit.
// clear holds the count at zero so the next state starts a fresh bit period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  // tick is registered alongside the count, so it is high exactly while count == LAST
  always_comb begin
    count_nxt = count + CNT_W'(1);
    if (clear || tick) begin
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= count_nxt;
      tick  <= (count_nxt == LAST);
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: start bit, FRAME_W data bits MSB-first, stop bit.
// A one-entry hold register accepts the next frame while the current one is on the line.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int FRAME_W      = 24
) (
  input  logic              clk,
  input  logic              reset,
  uart_frame_tx_if.slave    frm,
  output logic              uart_tx,
  output logic              busy,
  output logic              frame_done,
  output uart_state_t       dbg_state
);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $fatal(1, "uart_frame_tx: CLKS_PER_BIT must be >= 2");
    end
    if (FRAME_W < 8 || (FRAME_W % 8) != 0) begin : g_bad_fw
      $fatal(1, "uart_frame_tx: FRAME_W must be a multiple of 8 and >= 8");
    end
  endgenerate

  localparam int IDX_W = $clog2(FRAME_W);

  uart_state_t        state;
  logic [FRAME_W-1:0] hold_q;
  logic               hold_full;
  logic [FRAME_W-1:0] shifter;
  logic [IDX_W-1:0]   bit_idx;
  logic               tick;
  logic               baud_clear;
  logic               accept;
  logic               load;

  assign frm.frame_ready = !hold_full;
  assign accept          = frm.frame_valid && frm.frame_ready;
  // accept and load never coincide: load needs a full hold, accept needs an empty one
  assign load            = hold_full && ((state == IDLE) || (state == STOP && tick));
  assign baud_clear      = (state == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_q    <= frm.frame_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      uart_tx <= 1'b1;
      shifter <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (hold_full) begin
            shifter <= hold_q;
            state   <= START;
            uart_tx <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            bit_idx <= IDX_W'(FRAME_W - 1);
            uart_tx <= shifter[FRAME_W-1];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == '0) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              shifter <= shifter << 1;
              uart_tx <= shifter[FRAME_W-2];
              bit_idx <= bit_idx - IDX_W'(1);
            end
          end
        end
        STOP: begin
          // a frame already waiting in hold goes straight into its start bit
          if (tick) begin
            if (hold_full) begin
              shifter <= hold_q;
              state   <= START;
              uart_tx <= 1'b0;
            end else begin
              state   <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

  assign busy       = (state != IDLE) || hold_full;
  assign frame_done = (state == STOP) && tick;
  assign dbg_state  = state;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx (CLKS_PER_BIT=260, FRAME_W=24) with a line monitor
// that checks every line clock against the expected frame queue.
module tb_uart_frame_tx;
  import uart_pkg::*;

  localparam int BIT  = 260;
  localparam int FW   = 24;
  localparam int HALF = BIT / 2;
  localparam int LAST = (FW + 2) * BIT - 1;

  logic        clk;
  logic        rst;
  logic        uart_tx;
  logic        busy;
  logic        frame_done;
  uart_state_t dbg_state;

  uart_frame_tx_if #(.FRAME_W(FW)) f ();

  uart_frame_tx #(
    .CLKS_PER_BIT (BIT),
    .FRAME_W      (FW)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .frm        (f),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard and line monitor
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] cur_exp;
  logic [FW-1:0] mon_sh;
  logic          mon_active = 1'b0;
  int            mon_cnt = 0;
  int            cyc = 0;
  int            done_cyc = 0;
  int            last_gap = 0;
  int            frames_seen = 0;

  always @(negedge clk) begin
    logic exp_tx;
    logic exp_done;
    int   n;
    cyc++;
    if (rst) begin
      mon_active = 1'b0;
    end else if (mon_active) begin
      mon_cnt++;
    end else if (uart_tx == 1'b0) begin
      mon_active = 1'b1;
      mon_cnt    = 0;
      last_gap   = cyc - done_cyc;
      mon_sh     = '0;
      cur_exp    = (exp_q.size() > 0) ? exp_q[0] : '0;
    end
    exp_done = mon_active && (mon_cnt == LAST);
    check("frame_done", frame_done, exp_done);
    if (mon_active) begin
      if (mon_cnt < BIT)            exp_tx = 1'b0;
      else if (mon_cnt < 25 * BIT)  exp_tx = cur_exp[FW - mon_cnt / BIT];
      else                          exp_tx = 1'b1;
      check("line", uart_tx, exp_tx);
      if (mon_cnt >= BIT && mon_cnt < 25 * BIT && (mon_cnt % BIT) == HALF)
        mon_sh = {mon_sh[FW-2:0], uart_tx};
      if (mon_cnt == LAST) begin
        n = exp_q.size();
        check("sb_has_exp", n > 0, 1);
        if (n > 0) check("frame_data", mon_sh, exp_q.pop_front());
        frames_seen++;
        done_cyc   = cyc;
        mon_active = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic send_frame(input logic [FW-1:0] d, output int waited);
    waited = 0;
    @(negedge clk);
    f.frame_data  = d;
    f.frame_valid = 1'b1;
    while (!f.frame_ready && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    if (!f.frame_ready) begin
      check("accept_timeout", waited, 0);
      f.frame_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    f.frame_valid = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic wait_done();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_done && k < 20000);
    check("done_timeout", frame_done, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 40000);
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    int w;
    int zeros;
    rst           = 1'b1;
    f.frame_valid = 1'b0;
    f.frame_data  = '0;

    // 1: reset held
    repeat (5) begin
      @(negedge clk);
      check("rst_tx", uart_tx, 1);
      check("rst_ready", f.frame_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // 2: single frame, accept-to-start latency
    send_frame(24'h1350B0, w);
    @(negedge clk);
    check("acc_ready", f.frame_ready, 0);
    check("acc_busy", busy, 1);
    check("acc_tx", uart_tx, 1);
    @(negedge clk);
    check("load_tx", uart_tx, 0);
    check("load_state", 32'(dbg_state), 32'(START));
    check("load_ready", f.frame_ready, 1);
    wait_idle();
    check("t2_seen", frames_seen, 1);

    // 3: back-to-back, then accept on the stop-end edge
    send_frame(24'hA5A5A5, w);
    repeat (BIT * 5) @(posedge clk);
    send_frame(24'h0F0F0F, w);
    @(negedge clk);
    check("b2b_ready", f.frame_ready, 0);
    check("b2b_busy", busy, 1);
    repeat (BIT * 10) @(negedge clk);
    check("b2b_ready_hold", f.frame_ready, 0);
    wait_done();
    @(negedge clk);
    check("b2b_no_gap_tx", uart_tx, 0);
    check("b2b_state", 32'(dbg_state), 32'(START));
    wait_done();
    f.frame_data  = 24'h3C00C3;
    f.frame_valid = 1'b1;
    @(posedge clk);
    #1 f.frame_valid = 1'b0;
    exp_q.push_back(24'h3C00C3);
    @(negedge clk);
    check("stopend_idle_tx", uart_tx, 1);
    check("stopend_state", 32'(dbg_state), 32'(IDLE));
    wait_idle();
    check("stopend_gap", last_gap, 2);

    // 4: backpressure with three frames
    send_frame(24'hC3C3C3, w);
    send_frame(24'h123456, w);
    send_frame(24'h800001, w);
    check("bp_waited", w > 5000, 1);
    wait_idle();
    check("t4_seen", frames_seen, 7);

    // 5: reset during data bit 10 with a frame waiting in hold
    send_frame(24'h5A5A5A, w);
    send_frame(24'h777777, w);
    repeat (2900) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_tx", uart_tx, 1);
    check("mid_rst_ready", f.frame_ready, 1);
    check("mid_rst_busy", busy, 0);
    zeros = 0;
    repeat (BIT * 2) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) zeros++;
    end
    check("mid_rst_line_idle", zeros, 0);
    send_frame(24'h000001, w);
    wait_idle();

    // 6: two frames decoded by the monitor
    send_frame(24'h1350B0, w);
    send_frame(24'hFFFFFF, w);
    wait_idle();
    repeat (4) @(negedge clk);

    check("sb_empty", exp_q.size(), 0);
    check("frames_seen", frames_seen, 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
